// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline hazard / redirect controller.
//
// Arbitrates the requests that can disturb the in-order pipeline and turns them
// into a hold level, a PC redirect and an interrupt acknowledge. It also watches
// the data bus for stalls that run too long.
//
// Parameters
//   STALL_TO    consecutive bus-wait cycles before a timeout is flagged (1..1023)
//   RESET_ADDR  value driven on jump_addr_o whenever no redirect is in progress
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   jump_req_i/addr  branch or jump resolved in EX, and its target
//   int_req_i/addr   interrupt entry or mret request (level), and its vector
//   div_busy_i       multi-cycle divider occupies EX
//   bus_wait_i       data bus has not completed its access this cycle
//   load_use_i       ID detected a load-use hazard
//   err_clr_i        clears the sticky timeout flag
//   hold_flag_o      0=none 1=PC 2=IF/ID 3=ID/EX; each level includes those below it
//   jump_flag_o      redirect the PC this cycle, to jump_addr_o
//   int_ack_o        interrupt accepted this cycle
//   stall_timeout_o  single pulse when the bus-wait count reaches STALL_TO
//   stall_err_o      sticky timeout flag
//   state_o          0=RUN 1=FLUSH 2=STALL
module pipe_ctrl #(
    parameter int unsigned STALL_TO   = 255,
    parameter logic [31:0] RESET_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump_req_i,
    input  logic [31:0] jump_addr_i,
    input  logic        int_req_i,
    input  logic [31:0] int_addr_i,
    input  logic        div_busy_i,
    input  logic        bus_wait_i,
    input  logic        load_use_i,
    input  logic        err_clr_i,
    output logic [2:0]  hold_flag_o,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o,
    output logic        int_ack_o,
    output logic        stall_timeout_o,
    output logic        stall_err_o,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    localparam logic [2:0] HOLD_NONE  = 3'd0;
    localparam logic [2:0] HOLD_IF_ID = 3'd2;
    localparam logic [2:0] HOLD_ID_EX = 3'd3;

    localparam logic [9:0] STALL_TO_C = 10'(STALL_TO);

    state_t      state_q, state_d;
    logic [9:0]  wait_cnt_q;
    logic        err_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // Arbitration: next state and combinational outputs
    // ------------------------------------------------------------------
    // NOTE: every output is given a default first so no path leaves it
    // unassigned, which would infer a latch. rst_n also gates this block so
    // reset forces the outputs at once instead of waiting for a clock edge.
    always_comb begin
        state_d     = ST_RUN;
        hold_flag_o = HOLD_NONE;
        jump_flag_o = 1'b0;
        jump_addr_o = RESET_ADDR;
        int_ack_o   = 1'b0;

        if (rst_n) begin
            case (state_q)
                // One bubble while the instruction ROM returns the word at
                // the new PC; new redirects wait for the following RUN cycle.
                ST_FLUSH: begin
                    hold_flag_o = HOLD_IF_ID;
                    state_d     = ST_RUN;
                end
                // RUN and STALL arbitrate identically; STALL just reports
                // that the previous cycle was held by divider or bus.
                default: begin
                    if (int_req_i) begin
                        int_ack_o   = 1'b1;
                        jump_flag_o = 1'b1;
                        jump_addr_o = int_addr_i;
                        hold_flag_o = HOLD_ID_EX;
                        state_d     = ST_FLUSH;
                    end else if (jump_req_i) begin
                        jump_flag_o = 1'b1;
                        jump_addr_o = jump_addr_i;
                        hold_flag_o = HOLD_ID_EX;
                        state_d     = ST_FLUSH;
                    end else if (div_busy_i || bus_wait_i) begin
                        hold_flag_o = HOLD_ID_EX;
                        state_d     = ST_STALL;
                    end else if (load_use_i) begin
                        hold_flag_o = HOLD_IF_ID;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Bus-wait watchdog
    // ------------------------------------------------------------------
    // The pulse fires in the wait cycle that brings the count to STALL_TO,
    // i.e. while the registered count is still one below it. Once saturated
    // the count stops there, so the pulse cannot repeat until bus_wait_i drops.
    assign stall_timeout_o = rst_n && bus_wait_i && (wait_cnt_q == STALL_TO_C - 10'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else if (!bus_wait_i) begin
            wait_cnt_q <= '0;
        end else if (wait_cnt_q != STALL_TO_C) begin
            wait_cnt_q <= wait_cnt_q + 10'd1;
        end
    end

    // Set has priority over clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               err_q <= 1'b0;
        else if (stall_timeout_o) err_q <= 1'b1;
        else if (err_clr_i)       err_q <= 1'b0;
    end

    // The flag shows in the same cycle as the pulse, before err_q catches up.
    assign stall_err_o = err_q || stall_timeout_o;
    assign state_o     = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed scenarios followed by randomized traffic.
// The stimulus process drives one cycle at a time and pushes the response the
// reference model predicts for that cycle; an independent monitor pops each
// prediction and compares it with what the DUT shows in that cycle.
module tb_pipe_ctrl;

    localparam int          STALL_TO   = 255;
    localparam logic [31:0] RESET_ADDR = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        jump_req_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic        int_req_i = 1'b0;
    logic [31:0] int_addr_i = '0;
    logic        div_busy_i = 1'b0;
    logic        bus_wait_i = 1'b0;
    logic        load_use_i = 1'b0;
    logic        err_clr_i = 1'b0;
    logic [2:0]  hold_flag_o;
    logic        jump_flag_o;
    logic [31:0] jump_addr_o;
    logic        int_ack_o;
    logic        stall_timeout_o;
    logic        stall_err_o;
    logic [1:0]  state_o;

    pipe_ctrl #(.STALL_TO(STALL_TO), .RESET_ADDR(RESET_ADDR)) dut (
        .clk(clk), .rst_n(rst_n),
        .jump_req_i(jump_req_i), .jump_addr_i(jump_addr_i),
        .int_req_i(int_req_i), .int_addr_i(int_addr_i),
        .div_busy_i(div_busy_i), .bus_wait_i(bus_wait_i),
        .load_use_i(load_use_i), .err_clr_i(err_clr_i),
        .hold_flag_o(hold_flag_o), .jump_flag_o(jump_flag_o),
        .jump_addr_o(jump_addr_o), .int_ack_o(int_ack_o),
        .stall_timeout_o(stall_timeout_o), .stall_err_o(stall_err_o),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  state;
        logic [2:0]  hold;
        logic        jf;
        logic [31:0] addr;
        logic        ack;
        logic        to;
        logic        err;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: what happened in the previous cycle, plus the length
    // of the current run of bus waits and the sticky error.
    bit m_after_redirect = 1'b0;
    bit m_after_stall    = 1'b0;
    int m_waits          = 0;
    bit m_err            = 1'b0;

    task automatic check(input string name, input logic [40:0] act, input logic [40:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got state/hold/jf/addr/ack/to/err=%h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the predicted response.
    task automatic step(input logic rst, input logic ir, input logic [31:0] ia,
                        input logic jr, input logic [31:0] ja, input logic dv,
                        input logic bw, input logic lu, input logic clr, input string tag);
        exp_t e;
        bit   redirect, stall;
        @(negedge clk);
        rst_n = rst; int_req_i = ir; int_addr_i = ia; jump_req_i = jr;
        jump_addr_i = ja; div_busy_i = dv; bus_wait_i = bw; load_use_i = lu;
        err_clr_i = clr;

        e.tag = tag; e.hold = 3'd0; e.jf = 1'b0; e.addr = RESET_ADDR;
        e.ack = 1'b0; e.to = 1'b0; e.err = 1'b0; e.state = 2'd0;
        redirect = 1'b0; stall = 1'b0;
        if (!rst) begin
            m_waits = 0;
            m_err   = 1'b0;
        end else begin
            e.state = m_after_redirect ? 2'd1 : (m_after_stall ? 2'd2 : 2'd0);
            if (m_after_redirect)   e.hold = 3'd2;
            else if (ir)            begin e.ack = 1'b1; e.jf = 1'b1; e.addr = ia; e.hold = 3'd3; redirect = 1'b1; end
            else if (jr)            begin e.jf = 1'b1; e.addr = ja; e.hold = 3'd3; redirect = 1'b1; end
            else if (dv || bw)      begin e.hold = 3'd3; stall = 1'b1; end
            else if (lu)            e.hold = 3'd2;
            if (bw) begin
                m_waits++;
                e.to = (m_waits == STALL_TO);
            end else begin
                m_waits = 0;
            end
            e.err = m_err || e.to;
            if (e.to)     m_err = 1'b1;
            else if (clr) m_err = 1'b0;
        end
        m_after_redirect = redirect;
        m_after_stall    = stall;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    // Monitor: mid low phase, after the inputs for the cycle have settled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check(e.tag,
                      {state_o, hold_flag_o, jump_flag_o, jump_addr_o, int_ack_o, stall_timeout_o, stall_err_o},
                      {e.state, e.hold, e.jf, e.addr, e.ack, e.to, e.err});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int burst;
        // Reset state, including a jump request that reset must mask.
        step(0, 0, 0, 1, 32'h44, 0, 0, 0, 0, "reset");
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, "reset");
        idle(2, "idle");

        // Jump to 0x100, then FLUSH, then back to RUN.
        step(1, 0, 0, 1, 32'h100, 0, 0, 0, 0, "jump");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, "jump_flush");
        idle(1, "jump_after");

        // Interrupt beats a simultaneous jump; held request waits out FLUSH.
        step(1, 1, 32'h80, 1, 32'h200, 0, 0, 0, 0, "int_vs_jump");
        step(1, 1, 32'h80, 1, 32'h200, 0, 0, 0, 0, "int_flush_ignored");
        step(1, 0, 0, 1, 32'h200, 0, 0, 0, 0, "jump_after_flush");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, "flush2");
        idle(1, "int_after");

        // Divider busy for 4 cycles.
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 1, 0, 1, 0, "div_busy");
        idle(2, "div_release");

        // Load-use bubble.
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, "load_use");
        idle(1, "load_use_after");

        // Reset during FLUSH, with requests still asserted.
        step(1, 0, 0, 1, 32'h300, 0, 0, 0, 0, "jump_pre_reset");
        step(0, 1, 32'h90, 1, 32'h300, 1, 1, 1, 0, "reset_in_flush");
        idle(2, "after_reset");

        // Reset during STALL.
        step(1, 0, 0, 0, 0, 1, 0, 0, 0, "div_pre_reset");
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, "reset_in_stall");
        idle(1, "after_reset2");

        // Long bus wait: one timeout pulse, saturation, clear coinciding with
        // the set (set wins), then a clear while still waiting.
        for (int i = 0; i < 1300; i++)
            step(1, 0, 0, 0, 0, 0, 1, 0, (i == 254 || i == 800), "bus_wait_long");
        idle(2, "bus_release");
        // A second run exactly STALL_TO long re-arms and pulses again.
        for (int i = 0; i < STALL_TO; i++) step(1, 0, 0, 0, 0, 0, 1, 0, 0, "bus_wait_rearm");
        idle(1, "err_held");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, "err_clear");
        idle(1, "err_cleared");

        // Randomized traffic with bursty bus waits and occasional resets.
        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            logic bw;
            if (burst == 0 && $urandom_range(0, 9) == 0) burst = $urandom_range(1, 12);
            bw = (burst != 0);
            if (burst != 0) burst--;
            step($urandom_range(0, 199) != 0,
                 $urandom_range(0, 9) == 0, $urandom,
                 $urandom_range(0, 6) == 0, $urandom,
                 $urandom_range(0, 7) == 0, bw,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 9) == 0, "random");
        end

        // Let the monitor drain the queue, bounded.
        for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(negedge clk);
        #5;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have parameter STALL_TO, default 255, giving the consecutive bus-wait cycles before a timeout is flagged (legal range 1..1023).
REQ-002 The block SHALL have parameter RESET_ADDR, default 32'h0, giving the value that jump_addr_o drives when idle.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 jump_req_i  input  1  branch or jump resolved in EX this cycle.
REQ-006 jump_addr_i  input  32  branch or jump target.
REQ-007 int_req_i  input  1  interrupt entry or mret request (level) from the interrupt controller.
REQ-008 int_addr_i  input  32  trap vector or return address.
REQ-009 div_busy_i  input  1  multi-cycle divider is occupying EX.
REQ-010 bus_wait_i  input  1  data bus has not completed the access this cycle.
REQ-011 load_use_i  input  1  ID detected a load-use hazard.
REQ-012 err_clr_i  input  1  clears the sticky timeout flag.
REQ-013 hold_flag_o  output  3  0=HOLD_NONE, 1=HOLD_PC, 2=HOLD_IF_ID, 3=HOLD_ID_EX; a value at or above a level bubbles that stage and holds the PC.
REQ-014 jump_flag_o  output  1  redirect the PC this cycle.
REQ-015 jump_addr_o  output  32  redirect target.
REQ-016 int_ack_o  output  1  one-cycle pulse when an interrupt request is accepted.
REQ-017 stall_timeout_o  output  1  one-cycle pulse when the bus-wait count reaches STALL_TO.
REQ-018 stall_err_o  output  1  sticky timeout flag.
REQ-019 state_o  output  2  current FSM state: 0=RUN, 1=FLUSH, 2=STALL.

Function
REQ-020 The FSM SHALL have three states, RUN, FLUSH and STALL, and SHALL be in RUN after reset.
REQ-021 hold_flag_o, jump_flag_o, jump_addr_o and int_ack_o SHALL be combinational functions of the state and the inputs.
REQ-022 Request priority in RUN and STALL SHALL be, highest first: int_req_i, jump_req_i, div_busy_i, bus_wait_i, load_use_i.
REQ-023 When an interrupt is accepted, the block SHALL assert int_ack_o=1, jump_flag_o=1, jump_addr_o=int_addr_i and hold_flag_o=HOLD_ID_EX, then go to FLUSH.
REQ-024 When a jump wins arbitration, the block SHALL assert jump_flag_o=1, jump_addr_o=jump_addr_i and hold_flag_o=HOLD_ID_EX, then go to FLUSH.
REQ-025 If int_req_i and jump_req_i are both asserted in the same cycle, the interrupt SHALL win and the jump SHALL be dropped with no jump_flag_o for it.
REQ-026 FLUSH SHALL last exactly 1 cycle with hold_flag_o=HOLD_IF_ID and jump_flag_o=0, covering the instruction ROM's 1-cycle read latency, then return to RUN.
REQ-027 In FLUSH, int_req_i and jump_req_i SHALL be ignored; a request still held high SHALL be accepted in the following RUN cycle.
REQ-028 div_busy_i or bus_wait_i as the winning request SHALL give hold_flag_o=HOLD_ID_EX and next state STALL.
REQ-029 The block SHALL return from STALL to RUN in the first cycle in which both div_busy_i and bus_wait_i are 0.
REQ-030 load_use_i as the winning request SHALL give hold_flag_o=HOLD_IF_ID for exactly that cycle, with the state remaining RUN.
REQ-031 With no request asserted, the outputs SHALL be hold_flag_o=HOLD_NONE, jump_flag_o=0 and jump_addr_o=RESET_ADDR.
REQ-032 A 10-bit counter SHALL increment in every cycle with bus_wait_i=1 and SHALL clear to 0 in any cycle with bus_wait_i=0.
REQ-033 The counter SHALL saturate at STALL_TO and never wrap.
REQ-034 stall_timeout_o SHALL pulse once, in the cycle the counter reaches STALL_TO, and not again until the counter has cleared.
REQ-035 The counter reaching STALL_TO SHALL set stall_err_o in that same cycle.
REQ-036 stall_err_o SHALL be cleared by err_clr_i; if the set and clear events coincide, the set SHALL win.
REQ-037 The stall timeout SHALL NOT release the stall; the pipeline SHALL remain held until bus_wait_i falls.

Reset
REQ-038 rst_n=0 SHALL immediately force the following outputs and state:
- state RUN, counter 0, stall_err_o=0;
- hold_flag_o=HOLD_NONE, jump_flag_o=0, int_ack_o=0, stall_timeout_o=0;
- jump_addr_o=RESET_ADDR.
REQ-039 Reset asserted mid-FLUSH or mid-STALL SHALL abort the sequence, with no residual hold after reset is released.

Verification
REQ-040 jump_req_i=1 with jump_addr_i=0x100 for 1 cycle -> that cycle: jump_flag_o=1, jump_addr_o=0x100, hold=3; next cycle: hold=2, state FLUSH; cycle after that: hold=0.
REQ-041 int_req_i=1 and jump_req_i=1 in the same cycle, int_addr_i=0x80 -> int_ack_o=1, jump_addr_o=0x80, and no redirect to the jump target.
REQ-042 bus_wait_i=1 held for 300 cycles with STALL_TO=255 -> stall_timeout_o pulses once in the 255th wait cycle, hold=3 throughout, stall_err_o stays 1 until err_clr_i.
REQ-043 div_busy_i=1 for 4 cycles -> hold=3 for 4 cycles, state STALL, then RUN with hold=0.
REQ-044 load_use_i=1 for 1 cycle -> hold=2 for 1 cycle only, state_o stays 0.
REQ-045 rst_n pulsed low during FLUSH -> all outputs take their reset values immediately, and hold=0 after release.
